// File: rtl/num_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan decoder.
package num_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } scan_state_e;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;

  // Segment bit positions within num_a_g (a is the MSB).
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  // Select value when no digit is lit.
  localparam logic [7:0] CSN_IDLE = 8'hFF;

  // Standard hex glyphs, index = hex value (entry 15 listed first).
  localparam logic [15:0][SEG_W-1:0] HEX_GLYPH = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Reverse lookup of a 7-segment pattern to its hex value.
// Present only when NUM_SCAN_HEX_EN is defined.
`ifdef NUM_SCAN_HEX_EN
module seg_hex_decode
  import num_scan_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic             ok_c,
  output logic [3:0]       hex_c
);

  // Match against every glyph; glyphs are unique so at most one hits.
  always_comb begin
    ok_c  = 1'b0;
    hex_c = 4'h0;
    for (int g = 0; g < 16; g++) begin
      if (seg_i == HEX_GLYPH[g]) begin
        ok_c  = 1'b1;
        hex_c = 4'(g);
      end
    end
  end

endmodule
`endif

// File: rtl/num_scan_decoder.sv
// Rebuilds the 8 digit patterns of a time-multiplexed 7-segment scan and
// shows the pair selected by pair_sel as static patterns on dpy1/dpy0.
// Optional macro NUM_SCAN_HEX_EN adds hex_val/hex_ok reverse glyph decode.
module num_scan_decoder
  import num_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES    = 2   // legal range 2..3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] num_csn,
  input  logic [6:0] num_a_g,
  input  logic [1:0] pair_sel,
  output logic [7:0] dpy0,
  output logic [7:0] dpy1,
  output logic [7:0] digit_valid,
  output logic       scan_err
`ifdef NUM_SCAN_HEX_EN
  ,
  output logic [31:0] hex_val,
  output logic [7:0]  hex_ok
`endif
);

  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned AGE_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SAMP_W = 8 + SEG_W;

  logic [7:0]       csn_sync_q [SYNC_STAGES];
  logic [SEG_W-1:0] seg_sync_q [SYNC_STAGES];
  logic [7:0]       csn_s;
  logic [SEG_W-1:0] seg_s;
  logic [SAMP_W-1:0] samp_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed_c, slot_done_c, one_hot_c, slot_err_c;
  logic [7:0]       cap_c;
  scan_state_e      state_q;
  logic [SEG_W-1:0] digit_seg_q [NUM_DIGITS];
  logic [AGE_W-1:0] age_q [NUM_DIGITS];
  logic [7:0]       valid_q;
  logic [2:0]       lo_idx, hi_idx;

  assign csn_s       = csn_sync_q[SYNC_STAGES-1];
  assign seg_s       = seg_sync_q[SYNC_STAGES-1];
  assign changed_c   = ({csn_s, seg_s} != samp_q);
  assign one_hot_c   = $onehot(~csn_s);
  // A slot completes on the cycle the counter reaches the threshold.
  assign slot_done_c = (state_q == ST_SETTLE) && (csn_s != CSN_IDLE) &&
                       (cnt_d == CNT_W'(STABLE_CYCLES));
  assign cap_c       = (slot_done_c && one_hot_c) ? ~csn_s : 8'h00;
  assign slot_err_c  = slot_done_c && !one_hot_c;
  assign lo_idx      = {pair_sel, 1'b0};
  assign hi_idx      = {pair_sel, 1'b1};
  assign digit_valid = valid_q;

  // Input synchronizers, reset to the idle scan value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        csn_sync_q[s] <= CSN_IDLE;
        seg_sync_q[s] <= '0;
      end
    end else begin
      csn_sync_q[0] <= num_csn;
      seg_sync_q[0] <= num_a_g;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        csn_sync_q[s] <= csn_sync_q[s-1];
        seg_sync_q[s] <= seg_sync_q[s-1];
      end
    end
  end

  // Stability count: reload to 1 on any sample change, else saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (changed_c) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Previous-sample register and stability counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      samp_q <= {CSN_IDLE, SEG_W'(0)};
      cnt_q  <= '0;
    end else begin
      samp_q <= {csn_s, seg_s};
      cnt_q  <= cnt_d;
    end
  end

  // Slot FSM with registered one-cycle error pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      scan_err <= 1'b0;
    end else begin
      scan_err <= slot_err_c;
      case (state_q)
        ST_IDLE: begin
          if (csn_s != CSN_IDLE) state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (slot_done_c)             state_q <= ST_CAPTURED;
          else if (csn_s == CSN_IDLE)  state_q <= ST_IDLE;
        end
        ST_CAPTURED: begin
          if (changed_c) state_q <= (csn_s == CSN_IDLE) ? ST_IDLE : ST_SETTLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Digit store and age counters; a capture beats a same-cycle timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        digit_seg_q[d] <= '0;
        age_q[d]       <= '0;
      end
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (cap_c[d]) begin
          digit_seg_q[d] <= seg_s;
          age_q[d]       <= '0;
          valid_q[d]     <= 1'b1;
        end else if (age_q[d] != AGE_W'(TIMEOUT_CYCLES)) begin
          age_q[d] <= age_q[d] + AGE_W'(1);
          if (age_q[d] + AGE_W'(1) == AGE_W'(TIMEOUT_CYCLES)) valid_q[d] <= 1'b0;
        end
      end
    end
  end

  // Registered display pair; stale digits are blanked.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dpy0 <= 8'h00;
      dpy1 <= 8'h00;
    end else begin
      dpy0 <= valid_q[lo_idx] ? {digit_seg_q[lo_idx], 1'b0} : 8'h00;
      dpy1 <= valid_q[hi_idx] ? {digit_seg_q[hi_idx], 1'b0} : 8'h00;
    end
  end

`ifdef NUM_SCAN_HEX_EN
  logic [31:0] hex_c;
  logic [7:0]  ok_c;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_hex_decode u_dec (
      .seg_i (digit_seg_q[g]),
      .ok_c  (ok_c[g]),
      .hex_c (hex_c[4*g +: 4])
    );
  end

  // Registered hex view; ok only for valid digits with a standard glyph.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hex_val <= '0;
      hex_ok  <= '0;
    end else begin
      hex_val <= hex_c;
      hex_ok  <= ok_c & valid_q;
    end
  end
`endif

endmodule
